// File: rtl/chi_pkg.sv
// Shared command encodings, FSM state type and request payload for the CHI request node.
package chi_pkg;

  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_READ  = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } chi_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } chi_req_t;

  function automatic logic [31:0] alignWord(input logic [31:0] byteAddr);
    return {byteAddr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/chi_req_fifo.sv
// Client request queue: power-of-two depth, pointers wrap naturally, occupancy tracked separately.
module chi_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/chi_request_node.sv
// CHI-style request node: queues client requests and issues them one at a time to a slave,
// with a response timeout that turns a silent slave into an error completion.
module chi_request_node
  import chi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_write_o,
  output logic        rsp_error_o,
  output logic [31:0] addr_o,
  output logic [3:0]  command_o,
  output logic [31:0] write_data_o,
  output logic        request_valid_o,
  input  logic [31:0] read_data_i,
  input  logic        response_valid_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  chi_state_e  state_q, state_d;
  logic        issueWrite_q, issueWrite_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [31:0] rspRdata_q, rspRdata_d;
  logic        rspWrite_q, rspWrite_d;
  logic        rspError_q, rspError_d;

  chi_req_t    pushReq, headReq;
  logic        fifoFull, fifoEmpty, fifoPop;

  assign pushReq = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};

  chi_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(chi_req_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_valid_i),
    .data_i  (pushReq),
    .pop_i   (fifoPop),
    .data_o  (headReq),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign req_ready_o     = !fifoFull;
  assign request_valid_o = (state_q == ISSUE);
  assign command_o       = (state_q == ISSUE) ? (issueWrite_q ? CMD_WRITE : CMD_READ) : CMD_NONE;
  assign addr_o          = addr_q;
  assign write_data_o    = wdata_q;
  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_rdata_o     = rspRdata_q;
  assign rsp_write_o     = rspWrite_q;
  assign rsp_error_o     = rspError_q;

  // A response arriving on the final WAIT cycle still wins over the timeout.
  always_comb begin
    state_d      = state_q;
    issueWrite_d = issueWrite_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    timer_d      = timer_q;
    rspRdata_d   = rspRdata_q;
    rspWrite_d   = rspWrite_q;
    rspError_d   = rspError_q;
    fifoPop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop      = 1'b1;
          issueWrite_d = headReq.write;
          addr_d       = alignWord(headReq.addr);
          wdata_d      = headReq.write ? headReq.wdata : 32'h0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (response_valid_i) begin
          rspRdata_d = issueWrite_q ? 32'h0 : read_data_i;
          rspWrite_d = issueWrite_q;
          rspError_d = 1'b0;
          state_d    = RESP;
        end else if (timer_q == CW'(TIMEOUT - 1)) begin
          rspRdata_d = 32'h0;
          rspWrite_d = issueWrite_q;
          rspError_d = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      issueWrite_q <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      timer_q      <= '0;
      rspRdata_q   <= 32'h0;
      rspWrite_q   <= 1'b0;
      rspError_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issueWrite_q <= issueWrite_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      timer_q      <= timer_d;
      rspRdata_q   <= rspRdata_d;
      rspWrite_q   <= rspWrite_d;
      rspError_q   <= rspError_d;
    end
  end

endmodule

// File: tb/tb_chi_request_node.sv
// Scoreboard bench for chi_request_node: expected slave requests and client completions are queued
// at stimulus time and popped by independent monitors whenever the DUT presents them.
module tb_chi_request_node;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, rsp_ready, response_valid;
  logic [31:0] req_addr, req_wdata, read_data;
  logic        req_ready_o, rsp_valid_o, rsp_write_o, rsp_error_o, request_valid_o;
  logic [31:0] rsp_rdata_o, addr_o, write_data_o;
  logic [3:0]  command_o;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqExp_t;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        error;
  } rspExp_t;

  reqExp_t reqQ[$];
  rspExp_t rspQ[$];

  int vectors = 0;
  int miscompares = 0;
  int cycleCount = 0;
  int reqPulses = 0;
  int rspCount = 0;
  int lastPushCycle = 0;
  int lastReqCycle = 0;
  int lastRspCycle = 0;
  int snapRsp, snapReq;

  logic        slaveMute = 1'b0;
  int          slaveDelay = 1;
  logic        strayReq = 1'b0;
  logic [31:0] mem [0:63];

  chi_request_node #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .req_write_i      (req_write),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_write_o      (rsp_write_o),
    .rsp_error_o      (rsp_error_o),
    .addr_o           (addr_o),
    .command_o        (command_o),
    .write_data_o     (write_data_o),
    .request_valid_o  (request_valid_o),
    .read_data_i      (read_data),
    .response_valid_i (response_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic boundExpired(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired, got none, expected event", name);
  endtask

  // Called at posedge+1; holds req_valid until the handshake edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] expAddr, input logic [31:0] expRdata,
                               input logic expErr);
    int guard = 0;
    reqExp_t re;
    rspExp_t rs;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready_o && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      boundExpired("push_handshake");
    end else begin
      re.cmd   = wr ? 4'b0010 : 4'b0001;
      re.addr  = expAddr;
      re.wdata = wr ? wd : 32'h0;
      reqQ.push_back(re);
      rs.write = wr;
      rs.rdata = expRdata;
      rs.error = expErr;
      rspQ.push_back(rs);
      @(posedge clk); #1;
      lastPushCycle = cycleCount - 1;
    end
    req_valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int g = 0;
    while ((rspQ.size() != 0 || reqQ.size() != 0) && g < maxCycles) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= maxCycles) boundExpired("drain");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"},     32'(req_ready_o), 32'd1);
    checkOutput({tag, "_request_valid"}, 32'(request_valid_o), 32'd0);
    checkOutput({tag, "_command"},       32'(command_o), 32'd0);
    checkOutput({tag, "_addr"},          addr_o, 32'h0);
    checkOutput({tag, "_write_data"},    write_data_o, 32'h0);
    checkOutput({tag, "_rsp_valid"},     32'(rsp_valid_o), 32'd0);
    checkOutput({tag, "_rsp_rdata"},     rsp_rdata_o, 32'h0);
    checkOutput({tag, "_rsp_write"},     32'(rsp_write_o), 32'd0);
    checkOutput({tag, "_rsp_error"},     32'(rsp_error_o), 32'd0);
  endtask

  // Slave request monitor: every pulse must match the oldest expected request.
  always @(negedge clk) begin : reqMonitor
    reqExp_t e;
    if (!reset && request_valid_o) begin
      reqPulses++;
      lastReqCycle = cycleCount;
      if (reqQ.size() == 0) begin
        boundExpired("unexpected_request_valid");
      end else begin
        e = reqQ.pop_front();
        checkOutput("req_command", 32'(command_o), 32'(e.cmd));
        checkOutput("req_addr", addr_o, e.addr);
        checkOutput("req_write_data", write_data_o, e.wdata);
      end
    end
  end

  // Client completion monitor: pops on handshake, checks stability while stalled.
  always @(negedge clk) begin : rspMonitor
    rspExp_t e;
    if (!reset && rsp_valid_o) begin
      if (rspQ.size() == 0) begin
        boundExpired("unexpected_rsp_valid");
      end else if (rsp_ready) begin
        e = rspQ.pop_front();
        rspCount++;
        lastRspCycle = cycleCount;
        checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
        checkOutput("rsp_write", 32'(rsp_write_o), 32'(e.write));
        checkOutput("rsp_error", 32'(rsp_error_o), 32'(e.error));
      end else begin
        e = rspQ[0];
        checkOutput("rsp_hold_rdata", rsp_rdata_o, e.rdata);
        checkOutput("rsp_hold_error", 32'(rsp_error_o), 32'(e.error));
      end
    end
  end

  // Slave model: responds slaveDelay cycles after the request pulse unless muted.
  initial begin : slaveModel
    int widx;
    logic isWrite;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[3] = 32'hDEAD_BEEF;
    response_valid = 1'b0;
    read_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (strayReq) begin
        response_valid = 1'b1;
        read_data = 32'h5555_AAAA;
        strayReq = 1'b0;
        @(posedge clk); #1;
        response_valid = 1'b0;
        read_data = 32'h0;
      end else if (!reset && request_valid_o) begin
        widx = int'(addr_o[7:2]);
        isWrite = (command_o == 4'b0010);
        if (isWrite) mem[widx] = write_data_o;
        if (!slaveMute) begin
          for (int k = 0; k < slaveDelay && !reset; k++) begin
            @(posedge clk); #1;
          end
          if (!reset) begin
            response_valid = 1'b1;
            read_data = isWrite ? 32'hBAD0_BAD0 : mem[widx];
            @(posedge clk); #1;
            response_valid = 1'b0;
            read_data = 32'h0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] read of word 3");
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
    waitDrain(50);
    checkOutput("read_request_latency", 32'(lastReqCycle - lastPushCycle), 32'd2);
    checkOutput("read_rsp_latency", 32'(lastRspCycle - lastPushCycle), 32'd4);

    $display("[TB] write then read");
    applyStimulus(1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0000_0010, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0010, 32'hA5A5_0001, 1'b0);
    waitDrain(100);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    snapReq = reqPulses;
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0020, 32'h1000_0008, 1'b0);
    applyStimulus(1'b0, 32'h0000_0024, 32'h0, 32'h0000_0024, 32'h1000_0009, 1'b0);
    applyStimulus(1'b0, 32'h0000_0028, 32'h0, 32'h0000_0028, 32'h1000_000A, 1'b0);
    applyStimulus(1'b0, 32'h0000_002C, 32'h0, 32'h0000_002C, 32'h1000_000B, 1'b0);
    applyStimulus(1'b1, 32'h0000_0030, 32'h7777_0005, 32'h0000_0030, 32'h0, 1'b0);
    checkOutput("full_req_ready", 32'(req_ready_o), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("stalled_request_pulses", 32'(reqPulses - snapReq), 32'd1);
    checkOutput("stalled_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("stalled_req_ready", 32'(req_ready_o), 32'd0);
    rsp_ready = 1'b1;
    waitDrain(200);
    checkOutput("drained_request_pulses", 32'(reqPulses - snapReq), 32'd5);

    $display("[TB] timeout with silent slave");
    slaveMute = 1'b1;
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, 32'h0000_0014, 32'h0, 1'b1);
    waitDrain(100);
    checkOutput("timeout_latency", 32'(lastRspCycle - lastReqCycle), 32'(TIMEOUT + 1));
    slaveMute = 1'b0;

    $display("[TB] response on the last wait cycle");
    slaveDelay = TIMEOUT;
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
    waitDrain(100);
    checkOutput("late_rsp_latency", 32'(lastRspCycle - lastReqCycle), 32'(TIMEOUT + 1));
    slaveDelay = 1;

    $display("[TB] reset during wait with two queued");
    slaveMute = 1'b1;
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 32'h0000_000C, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0020, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0024, 32'h0, 32'h0000_0024, 32'h0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reqQ.delete();
    rspQ.delete();
    snapRsp = rspCount;
    snapReq = reqPulses;
    #1;
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    slaveMute = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("postreset_completions", 32'(rspCount - snapRsp), 32'd0);
    checkOutput("postreset_request_pulses", 32'(reqPulses - snapReq), 32'd0);
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
    waitDrain(50);
    checkOutput("postreset_rsp_latency", 32'(lastRspCycle - lastPushCycle), 32'd4);

    $display("[TB] unaligned address");
    applyStimulus(1'b0, 32'h0000_0013, 32'h0, 32'h0000_0010, 32'hA5A5_0001, 1'b0);
    waitDrain(50);
    checkOutput("idle_addr_hold", addr_o, 32'h0000_0010);
    checkOutput("idle_command", 32'(command_o), 32'd0);

    $display("[TB] stray response in idle");
    snapRsp = rspCount;
    strayReq = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("stray_completions", 32'(rspCount - snapRsp), 32'd0);
    checkOutput("stray_rsp_valid", 32'(rsp_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chi_request_node.md
CHI_REQUEST_NODE -- requirements
Module: chi_request_node

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, request queue entries (power of 2, >=2); TIMEOUT, default 16, max cycles WAIT holds before error.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  client request offered.
REQ-005 req_ready  output  1  queue can accept; equals !fifo_full.
REQ-006 req_write  input  1  1=write, 0=read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  completion available to client.
REQ-010 rsp_ready  input  1  client accepts completion.
REQ-011 rsp_rdata  output  32  read data (0 for writes and errors).
REQ-012 rsp_write  output  1  completion is for a write.
REQ-013 rsp_error  output  1  completion timed out.
REQ-014 addr  output  32  request address to slave node.
REQ-015 command  output  4  4'b0001 read, 4'b0010 write, 4'b0000 when idle.
REQ-016 write_data  output  32  write payload to slave.
REQ-017 request_valid  output  1  single-cycle request strobe to slave.
REQ-018 read_data  input  32  slave read data, valid with response_valid.
REQ-019 response_valid  input  1  slave completion strobe.

Function
REQ-020 Client request SHALL be pushed into the FIFO on any cycle where req_valid && req_ready; push and pop in the same cycle SHALL both take effect.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: FIFO non-empty -> pop head into issue registers, go ISSUE; otherwise stay.
REQ-023 ISSUE: request_valid=1 for exactly one cycle with addr, command, write_data from the issue registers; go WAIT unconditionally.
REQ-024 addr SHALL be driven as {req_addr[31:2],2'b00}; write_data SHALL be 0 for reads.
REQ-025 WAIT: timeout counter SHALL start at 0 on entry and increment each cycle; response_valid=1 -> capture read_data (reads) and go RESP with rsp_error=0.
REQ-026 WAIT: counter reaching TIMEOUT-1 without response_valid -> go RESP with rsp_error=1, rsp_rdata=0.
REQ-027 response_valid in the same cycle as timeout expiry SHALL win (rsp_error=0).
REQ-028 response_valid while in IDLE, ISSUE or RESP SHALL be ignored.
REQ-029 RESP: rsp_valid=1 with rsp_rdata/rsp_write/rsp_error stable until rsp_ready; on handshake go IDLE (next pop one cycle later).
REQ-030 Outside ISSUE, request_valid=0, command=4'b0000, addr and write_data hold last values.
REQ-031 Only one transaction SHALL be outstanding to the slave at any time.
REQ-032 Nominal latency: push cycle N -> request_valid at N+2 -> response_valid at N+3 -> rsp_valid at N+4.
REQ-033 FIFO full: req_ready=0 and further req_valid SHALL be held off, never dropped or overwritten.
REQ-034 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-035 reset SHALL asynchronously force state IDLE, FIFO empty, counter 0, request_valid=0, command=0, addr=0, write_data=0, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_error=0, req_ready=1.
REQ-036 Reset mid-transaction SHALL discard queued and in-flight requests without any client completion; first request after deassertion SHALL issue normally.

Structure
REQ-037 Package chi_pkg SHALL hold CMD_READ, CMD_WRITE, CMD_NONE constants and the state enum type.
REQ-038 Request queue SHALL be sub-module chi_req_fifo (parameterised depth/width, push/pop/full/empty); FSM and timeout in top.

Verification
REQ-039 Read: slave memory word 3 = 32'hDEADBEEF, push read addr 32'h0C -> one request_valid pulse, command 4'b0001, rsp_rdata=32'hDEADBEEF, rsp_error=0 at N+4.
REQ-040 Write-then-read: push write addr 32'h10 data 32'hA5A5_0001, then read 32'h10 -> two pulses in order, second rsp_rdata=32'hA5A5_0001.
REQ-041 Backpressure: rsp_ready=0, push 5 requests -> req_ready=0 after FIFO fills (4 queued + 1 in flight), no second request_valid until rsp_ready=1; all 5 completions in order.
REQ-042 Timeout: slave model never responds -> rsp_valid with rsp_error=1, rsp_rdata=0 exactly TIMEOUT cycles after ISSUE; response at cycle TIMEOUT-1 instead -> rsp_error=0.
REQ-043 Reset mid-WAIT with 2 queued -> outputs at reset values immediately, no rsp_valid, queue empty, subsequent read completes normally.
REQ-044 Unaligned addr 32'h0000_0013 -> addr driven 32'h0000_0010; stray response_valid in IDLE -> no rsp_valid.
